// File: rtl/pipe_stage_buffer_pkg.sv
// Shared defaults and control-bit naming for the pipeline stage buffer.
package pipe_stage_buffer_pkg;

    localparam int LANES_DEF  = 2;
    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 3;
    localparam int TAG_W_DEF  = 37;

    // Bit positions inside the control vector.
    typedef enum logic [1:0] {
        CTRL_MEMREAD  = 2'd0,
        CTRL_MEMTOREG = 2'd1,
        CTRL_REGWRITE = 2'd2
    } ctrl_bit_e;

    function automatic bit lanes_legal(input int lanes);
        return (lanes >= 1) && (lanes <= 4);
    endfunction

endpackage

// File: rtl/pipe_stage_entry_reg.sv
// One pipeline entry register. Clearing drops valid and zeroes ctrl/lane_en
// only; tag and data keep their last loaded value. Disabled lanes load as zero.
module pipe_stage_entry_reg
    import pipe_stage_buffer_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    load,
    input  logic                    clear,
    input  logic [CTRL_W-1:0]       new_ctrl,
    input  logic [TAG_W-1:0]        new_tag,
    input  logic [LANES-1:0]        new_lane_en,
    input  logic [LANES*DATA_W-1:0] new_data,
    output logic                    valid,
    output logic [CTRL_W-1:0]       ctrl,
    output logic [TAG_W-1:0]        tag,
    output logic [LANES-1:0]        lane_en,
    output logic [LANES*DATA_W-1:0] data
);

    logic                    valid_reg;
    logic [CTRL_W-1:0]       ctrl_reg;
    logic [TAG_W-1:0]        tag_reg;
    logic [LANES-1:0]        lane_en_reg;
    logic [LANES*DATA_W-1:0] data_reg;
    logic [LANES*DATA_W-1:0] masked_data;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_mask
            assign masked_data[gi*DATA_W +: DATA_W] =
                new_lane_en[gi] ? new_data[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            tag_reg     <= '0;
            lane_en_reg <= '0;
            data_reg    <= '0;
        end else if (clear) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            lane_en_reg <= '0;
        end else if (load) begin
            valid_reg   <= 1'b1;
            ctrl_reg    <= new_ctrl;
            tag_reg     <= new_tag;
            lane_en_reg <= new_lane_en;
            data_reg    <= masked_data;
        end
    end

    assign valid   = valid_reg;
    assign ctrl    = ctrl_reg;
    assign tag     = tag_reg;
    assign lane_en = lane_en_reg;
    assign data    = data_reg;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline stage register with flush. Define PIPE_STAGE_SKID_EN
// to add a one-entry skid register and a registered in_ready.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [LANES-1:0]        in_lane_en,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [TAG_W-1:0]        out_tag,
    output logic [LANES-1:0]        out_lane_en,
    output logic [LANES*DATA_W-1:0] out_data
);

    logic                    accept;
    logic                    out_drain;
    logic                    out_load;
    logic                    out_clear;
    logic [CTRL_W-1:0]       src_ctrl;
    logic [TAG_W-1:0]        src_tag;
    logic [LANES-1:0]        src_lane_en;
    logic [LANES*DATA_W-1:0] src_data;

    assign out_drain = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                    skid_valid;
    logic                    skid_valid_next;
    logic                    skid_load;
    logic                    skid_clear;
    logic                    in_ready_reg;
    logic [CTRL_W-1:0]       skid_ctrl;
    logic [TAG_W-1:0]        skid_tag;
    logic [LANES-1:0]        skid_lane_en;
    logic [LANES*DATA_W-1:0] skid_data;

    assign accept = in_valid && in_ready_reg;

    // A held skid entry always refills the output first, which keeps order.
    assign out_load   = !flush && (skid_valid ? out_drain
                                              : (accept && (!out_valid || out_drain)));
    assign out_clear  = flush || (out_drain && !out_load);
    assign skid_load  = !flush && !skid_valid && accept && out_valid && !out_ready;
    assign skid_clear = flush || (skid_valid && out_drain);

    assign src_ctrl    = skid_valid ? skid_ctrl    : in_ctrl;
    assign src_tag     = skid_valid ? skid_tag     : in_tag;
    assign src_lane_en = skid_valid ? skid_lane_en : in_lane_en;
    assign src_data    = skid_valid ? skid_data    : in_data;

    always_comb begin
        skid_valid_next = skid_valid;
        if (flush)
            skid_valid_next = 1'b0;
        else if (skid_valid)
            skid_valid_next = !out_drain;
        else
            skid_valid_next = skid_load;
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            in_ready_reg <= 1'b1;
        else
            in_ready_reg <= !skid_valid_next;
    end

    assign in_ready = in_ready_reg;

    pipe_stage_entry_reg #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .TAG_W  (TAG_W)
    ) u_skid_reg (
        .Clk         (Clk),
        .Rst         (Rst),
        .load        (skid_load),
        .clear       (skid_clear),
        .new_ctrl    (in_ctrl),
        .new_tag     (in_tag),
        .new_lane_en (in_lane_en),
        .new_data    (in_data),
        .valid       (skid_valid),
        .ctrl        (skid_ctrl),
        .tag         (skid_tag),
        .lane_en     (skid_lane_en),
        .data        (skid_data)
    );
`else
    assign in_ready  = out_ready || !out_valid;
    assign accept    = in_valid && in_ready;
    assign out_load  = accept && !flush;
    assign out_clear = flush || (out_drain && !accept);

    assign src_ctrl    = in_ctrl;
    assign src_tag     = in_tag;
    assign src_lane_en = in_lane_en;
    assign src_data    = in_data;
`endif

    pipe_stage_entry_reg #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .TAG_W  (TAG_W)
    ) u_out_reg (
        .Clk         (Clk),
        .Rst         (Rst),
        .load        (out_load),
        .clear       (out_clear),
        .new_ctrl    (src_ctrl),
        .new_tag     (src_tag),
        .new_lane_en (src_lane_en),
        .new_data    (src_data),
        .valid       (out_valid),
        .ctrl        (out_ctrl),
        .tag         (out_tag),
        .lane_en     (out_lane_en),
        .data        (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed plus randomized bench for pipe_stage_buffer against a queue-based
// model; honours PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage_buffer;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;
    localparam int TAG_W  = 37;

    logic                    Clk;
    logic                    Rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [CTRL_W-1:0]       in_ctrl;
    logic [TAG_W-1:0]        in_tag;
    logic [LANES-1:0]        in_lane_en;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [TAG_W-1:0]        out_tag;
    logic [LANES-1:0]        out_lane_en;
    logic [LANES*DATA_W-1:0] out_data;

    pipe_stage_buffer #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .TAG_W  (TAG_W)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_tag      (in_tag),
        .in_lane_en  (in_lane_en),
        .in_data     (in_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_tag     (out_tag),
        .out_lane_en (out_lane_en),
        .out_data    (out_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [CTRL_W-1:0]       ctrl;
        logic [TAG_W-1:0]        tag;
        logic [LANES-1:0]        lane_en;
        logic [LANES*DATA_W-1:0] data;
    } ent_t;

    // Entries held by the stage, oldest (the one on the outputs) first.
    ent_t                    held[$];
    logic [TAG_W-1:0]        last_tag;
    logic [LANES*DATA_W-1:0] last_data;
    int                      cmp_cnt;
    int                      fail_cnt;
    int                      cyc;

    function automatic logic [LANES*DATA_W-1:0] lane_mask(input logic [LANES-1:0] en,
                                                          input logic [LANES*DATA_W-1:0] d);
        logic [LANES*DATA_W-1:0] r;
        r = d;
        for (int i = 0; i < LANES; i++)
            if (!en[i]) r[i*DATA_W +: DATA_W] = '0;
        return r;
    endfunction

    function automatic bit model_in_ready();
`ifdef PIPE_STAGE_SKID_EN
        return held.size() < 2;
`else
        return out_ready || (held.size() == 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp)
        else begin
            fail_cnt++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic                    ev;
        logic [CTRL_W-1:0]       e_ctrl;
        logic [LANES-1:0]        e_lane;
        logic [LANES*DATA_W-1:0] e_data;
        logic [TAG_W-1:0]        e_tag;
        ev     = held.size() > 0;
        e_ctrl = '0;
        e_lane = '0;
        e_data = last_data;
        e_tag  = last_tag;
        if (ev) begin
            e_ctrl = held[0].ctrl;
            e_lane = held[0].lane_en;
            e_data = held[0].data;
            e_tag  = held[0].tag;
        end
        chk("out_valid",   64'(out_valid),   64'(ev));
        chk("out_ctrl",    64'(out_ctrl),    64'(e_ctrl));
        chk("out_lane_en", 64'(out_lane_en), 64'(e_lane));
        chk("out_data",    64'(out_data),    64'(e_data));
        chk("out_tag",     64'(out_tag),     64'(e_tag));
        chk("in_ready",    64'(in_ready),    64'(model_in_ready()));
        $display("cyc=%0d rst=%0b flush=%0b in_v=%0b in_rdy=%0b out_v=%0b out_rdy=%0b ctrl=%0h lane=%0h data=%h",
                 cyc, Rst, flush, in_valid, in_ready, out_valid, out_ready, out_ctrl, out_lane_en, out_data);
    endtask

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        bit   rdy;
        bit   pop;
        bit   push;
        ent_t e;
        @(negedge Clk);
        check_outputs();
        rdy       = model_in_ready();
        pop       = (held.size() > 0) && out_ready;
        push      = in_valid && rdy;
        e.ctrl    = in_ctrl;
        e.tag     = in_tag;
        e.lane_en = in_lane_en;
        e.data    = lane_mask(in_lane_en, in_data);
        @(posedge Clk);
        if (Rst) begin
            held.delete();
            last_tag  = '0;
            last_data = '0;
        end else if (flush) begin
            held.delete();
        end else begin
            if (pop)  void'(held.pop_front());
            if (push) held.push_back(e);
        end
        if (!Rst && held.size() > 0) begin
            last_tag  = held[0].tag;
            last_data = held[0].data;
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [TAG_W-1:0] t,
                         input logic [LANES-1:0] le, input logic [LANES*DATA_W-1:0] d);
        in_valid   = v;
        in_ctrl    = c;
        in_tag     = t;
        in_lane_en = le;
        in_data    = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] r64;
        cmp_cnt   = 0;
        fail_cnt  = 0;
        cyc       = 0;
        last_tag  = '0;
        last_data = '0;
        Rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 3'b111, 37'h1F_0000_0001, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge Clk);
        #1;

        // Reset held two cycles with a valid input present.
        tick();
        tick();
        Rst = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        tick();

        // Back-to-back streaming.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'b101, TAG_W'(i), 2'b11, {32'(i * 8'h11), 32'(i * 8'h11)});
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        tick();
        tick();

        // Stall with 0xA5 held, 0xB6 offered.
        drive(1'b1, 3'b100, 37'h0A5, 2'b11, {32'h0A5, 32'h0A5});
        tick();
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 37'h0B6, 2'b11, {32'h0B6, 32'h0B6});
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 3; i++) tick();

        // Flush with a simultaneous input offer.
        drive(1'b1, 3'b001, 37'h0C7, 2'b11, {32'h0C7, 32'h0C7});
        tick();
        flush = 1'b1;
        drive(1'b1, 3'b111, 37'h0D8, 2'b11, {32'h0D8, 32'h0D8});
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        tick();
        tick();

        // Lane mask: lane 1 disabled.
        drive(1'b1, 3'b100, 37'h0E9, 2'b01, {32'hDEAD_BEEF, 32'h1234_5678});
        tick();
        drive(1'b0, '0, '0, '0, '0);
        tick();
        tick();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r64       = {$urandom, $urandom};
            Rst       = ($urandom_range(0, 127) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 3) != 0, CTRL_W'($urandom), r64[TAG_W-1:0],
                  LANES'($urandom), {$urandom, $urandom});
            tick();
        end
        Rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
